// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage: PC owner, single-outstanding imem requester, fetch FIFO
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] pc4_o,
  output logic [31:0] inst_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   redir_pc;

  logic [31:0]   pc4_mem  [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;

  // Low two bits of the redirect target are dropped so fetches stay word aligned.
  assign redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

  assign valid_o     = (count_q != '0);
  assign pc4_o       = valid_o ? pc4_mem[rd_ptr_q]  : 32'h0;
  assign inst_o      = valid_o ? inst_mem[rd_ptr_q] : 32'h0;
  assign imem_req_o  = (state_q == S_WAIT) || (state_q == S_DISCARD);
  assign imem_addr_o = fetch_pc_q;

  // Next-state: push/pop decisions, next occupancy, and fetch PC sequencing.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    push       = (state_q == S_WAIT) && imem_ack_i && !redirect_i;
    pop        = valid_o && !stall_i && !redirect_i;
    if (redirect_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
    case (state_q)
      S_IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
          state_d    = S_WAIT;
        end else if (count_d < FULL_CNT) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            fetch_pc_d = redir_pc;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (count_d < FULL_CNT) ? S_WAIT : S_IDLE;
          end
        end else if (redirect_i) begin
          // Request already on the bus: keep it until acked, remember where to go next.
          pend_pc_d = redir_pc;
          state_d   = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_ack_i) begin
          fetch_pc_d = redirect_i ? redir_pc : pend_pc_q;
          state_d    = S_WAIT;
        end else if (redirect_i) begin
          pend_pc_d = redir_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and fetch PC registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are masked by valid_o so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc4_mem[wr_ptr_q]  <= fetch_pc_q + 32'd4;
      inst_mem[wr_ptr_q] <= imem_data_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized and directed bench for if_fetch_queue against a queue model
module tb_if_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_i, imem_req_o, imem_ack_i, stall_i, redirect_i, valid_o;
  logic [31:0] imem_addr_o, imem_data_i, redirect_pc_i, pc4_o, inst_o;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .pc4_o(pc4_o), .inst_o(inst_o)
  );

  int checks = 0;
  int errors = 0;

  ent_t        q[$];
  logic [31:0] m_fpc, m_pend;
  bit          m_out, m_stale;

  bit          rst_v, stall_v, redir_v, force_ack, cmp_en;
  logic [31:0] rpc_v;
  int          lat_mode;
  bit          mem_active;
  int          mem_cnt, mem_lat;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc4, obs_inst;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc   = RESET_PC;
    m_pend  = 32'h0;
    m_out   = 1'b0;
    m_stale = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit ack, input bit stall, input bit redir,
                            input logic [31:0] rpc);
    logic [31:0] tgt;
    bit          popped;
    bit          keep;
    if (rst) begin
      model_reset();
      return;
    end
    tgt    = {rpc[31:2], 2'b00};
    popped = (q.size() != 0) && !stall && !redir;
    keep   = m_out && !ack;
    if (popped) void'(q.pop_front());
    if (m_out && ack) begin
      if (!m_stale && !redir) begin
        q.push_back({m_fpc + 32'd4, memf(m_fpc)});
        m_fpc = m_fpc + 32'd4;
      end else begin
        m_fpc = redir ? tgt : m_pend;
      end
      m_stale = 1'b0;
    end else if (m_out && redir) begin
      m_stale = 1'b1;
      m_pend  = tgt;
    end else if (!m_out && redir) begin
      m_fpc = tgt;
    end
    if (redir) q.delete();
    if (!keep) m_out = redir || (q.size() < DEPTH);
  endtask

  task automatic cycle();
    bit          ack;
    logic [31:0] e_pc4, e_inst;
    @(negedge clk);
    obs_req   = imem_req_o;
    obs_addr  = imem_addr_o;
    obs_valid = valid_o;
    obs_pc4   = pc4_o;
    obs_inst  = inst_o;
    if (cmp_en) begin
      e_pc4  = (q.size() != 0) ? q[0].pc4  : 32'h0;
      e_inst = (q.size() != 0) ? q[0].inst : 32'h0;
      chk("req",   {31'b0, obs_req},   {31'b0, m_out});
      chk("addr",  obs_addr,           m_fpc);
      chk("valid", {31'b0, obs_valid}, {31'b0, (q.size() != 0)});
      chk("pc4",   obs_pc4,            e_pc4);
      chk("inst",  obs_inst,           e_inst);
    end
    ack = 1'b0;
    if (obs_req && !mem_active) begin
      mem_active = 1'b1;
      mem_cnt    = 0;
      mem_lat    = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end
    if (mem_active) begin
      if (mem_cnt >= mem_lat) begin
        ack        = 1'b1;
        mem_active = 1'b0;
      end else begin
        mem_cnt++;
      end
    end
    if (force_ack && obs_req) begin
      ack        = 1'b1;
      mem_active = 1'b0;
    end
    if (rst_v) mem_active = 1'b0;
    rst_i         = rst_v;
    stall_i       = stall_v;
    redirect_i    = redir_v;
    redirect_pc_i = rpc_v;
    imem_ack_i    = ack;
    imem_data_i   = ack ? memf(obs_addr) : $urandom();
    model_step(rst_v, ack, stall_v, redir_v, rpc_v);
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
  endtask

  initial begin
    int nreq;
    bit found;
    int stall_pct;
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_ack_i = 1'b0; imem_data_i = 32'h0;
    rst_v = 0; stall_v = 0; redir_v = 0; force_ack = 0; cmp_en = 0; rpc_v = 32'h0;
    lat_mode = 0; mem_active = 0; mem_cnt = 0; mem_lat = 0;
    model_reset();
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;

    // Reset state and zero-wait streaming from RESET_PC.
    cycle();
    chk("rst_req", {31'b0, obs_req}, 32'h0);
    chk("rst_addr", obs_addr, 32'h0);
    chk("rst_valid", {31'b0, obs_valid}, 32'h0);
    chk("rst_pc4", obs_pc4, 32'h0);
    chk("rst_inst", obs_inst, 32'h0);
    cycle();
    chk("t1_req0", {31'b0, obs_req}, 32'h1);
    chk("t1_addr0", obs_addr, 32'h0);
    cycle();
    chk("t1_addr4", obs_addr, 32'h4);
    chk("t1_valid", {31'b0, obs_valid}, 32'h1);
    chk("t1_pc4_4", obs_pc4, 32'h4);
    chk("t1_inst0", obs_inst, 32'h1357_9BDF);
    cycle();
    chk("t1_addr8", obs_addr, 32'h8);
    chk("t1_pc4_8", obs_pc4, 32'h8);
    cycle();
    chk("t1_pc4_12", obs_pc4, 32'hC);

    // Held stall fills the FIFO, then fetching resumes at 0x10.
    do_reset();
    stall_v = 1'b1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_req) nreq++;
    end
    chk("t2_pushes", nreq, 4);
    chk("t2_req_off", {31'b0, obs_req}, 32'h0);
    chk("t2_head", obs_pc4, 32'h4);
    stall_v = 1'b0;
    cycle();
    cycle();
    chk("t2_resume_req", {31'b0, obs_req}, 32'h1);
    chk("t2_resume_addr", obs_addr, 32'h10);

    // Redirect during a slow fetch: address held, data dropped, refetch at 0x40.
    do_reset();
    cycle(); cycle(); cycle();
    lat_mode = 3;
    cycle();
    chk("t3_addr8", obs_addr, 32'h8);
    redir_v = 1'b1; rpc_v = 32'h40;
    cycle();
    redir_v = 1'b0;
    cycle();
    chk("t3_hold1", obs_addr, 32'h8);
    cycle();
    chk("t3_hold2", obs_addr, 32'h8);
    cycle();
    chk("t3_new_addr", obs_addr, 32'h40);
    chk("t3_empty", {31'b0, obs_valid}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (obs_valid) found = 1'b1;
    end
    chk("t3_found", {31'b0, found}, 32'h1);
    chk("t3_pc4", obs_pc4, 32'h44);

    // Redirect to an unaligned target with three entries queued.
    lat_mode = 0;
    do_reset();
    stall_v = 1'b1;
    cycle(); cycle(); cycle(); cycle();
    redir_v = 1'b1; rpc_v = 32'h103;
    cycle();
    chk("t4_valid_before", {31'b0, obs_valid}, 32'h1);
    redir_v = 1'b0;
    cycle();
    chk("t4_flushed", {31'b0, obs_valid}, 32'h0);
    chk("t4_addr", obs_addr, 32'h100);

    // PC wrap across 2^32.
    stall_v = 1'b0;
    redir_v = 1'b1; rpc_v = 32'hFFFF_FFF8;
    cycle();
    redir_v = 1'b0;
    cycle();
    chk("t5_addr_f8", obs_addr, 32'hFFFF_FFF8);
    cycle();
    chk("t5_addr_fc", obs_addr, 32'hFFFF_FFFC);
    chk("t5_pc4_fc", obs_pc4, 32'hFFFF_FFFC);
    cycle();
    chk("t5_addr_0", obs_addr, 32'h0);
    chk("t5_pc4_0", obs_pc4, 32'h0);
    cycle();
    chk("t5_pc4_4", obs_pc4, 32'h4);

    // Reset mid-request with a late ack during reset.
    do_reset();
    stall_v = 1'b1;
    cycle(); cycle(); cycle();
    lat_mode = 5;
    cycle();
    chk("t6_two_queued", {31'b0, obs_valid}, 32'h1);
    rst_v = 1'b1; force_ack = 1'b1;
    cycle();
    rst_v = 1'b0; force_ack = 1'b0; lat_mode = 0;
    cycle();
    chk("t6_valid", {31'b0, obs_valid}, 32'h0);
    chk("t6_req", {31'b0, obs_req}, 32'h0);
    cycle();
    chk("t6_restart", obs_addr, RESET_PC);
    chk("t6_restart_req", {31'b0, obs_req}, 32'h1);

    // Randomized traffic: light stall, then heavy stall to exercise a full FIFO.
    lat_mode = -1;
    for (int ph = 0; ph < 2; ph++) begin
      stall_pct = (ph == 0) ? 30 : 80;
      for (int i = 0; i < 1500; i++) begin
        stall_v = ($urandom_range(0, 99) < stall_pct);
        redir_v = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 2))
          0:       rpc_v = $urandom();
          1:       rpc_v = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: rpc_v = 32'($urandom_range(0, 255));
        endcase
        rst_v     = ($urandom_range(0, 199) == 0);
        force_ack = 1'b0;
        cycle();
      end
    end
    rst_v = 1'b0; redir_v = 1'b0; stall_v = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
